// File: rtl/fsm_ctx_arbiter.sv
// Round-robin arbiter time-sharing one mod-4 sequence FSM next-state function across N_REQ saved contexts.
// Optional grant locking for atomic x bursts is enabled by defining FSM_CTX_ARB_LOCK_EN.
module fsm_ctx_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     x_bits,
    input  logic [N_REQ-1:0]     ctx_clr,
`ifdef FSM_CTX_ARB_LOCK_EN
    input  logic [N_REQ-1:0]     lock,
`endif
    output logic [N_REQ-1:0]     gnt,
    output logic                 gnt_valid,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic [1:0]           state_out,
    output logic                 wrap,
    output logic [2*N_REQ-1:0]   ctx_state
);

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    // Shared sequence step: s0 -> s3 -> s1 -> s2 -> s0 on x=1, hold on x=0.
    function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic x);
        logic [1:0] n;
        if (x) begin
            case (s)
                S0:      n = S3;
                S3:      n = S1;
                S1:      n = S2;
                S2:      n = S0;
                default: n = S0;
            endcase
        end else begin
            n = s;
        end
        return n;
    endfunction

    logic [1:0]       ctx_r [N_REQ];
    logic [IDX_W-1:0] ptr_r;

    logic             found_s;
    logic [IDX_W-1:0] win_s;
    logic [IDX_W-1:0] cand_s;
    int               cand_int_s;
    logic             hold_s;
    logic             grant_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic [1:0]       cur_s;
    logic             x_s;
    logic             clr_w_s;
    logic [1:0]       new_state_s;
    logic             wrap_s;
    logic [IDX_W-1:0] ptr_nxt_s;
    logic [N_REQ-1:0] gnt_nxt_s;

    // Round-robin search: first requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found_s    = 1'b0;
        win_s      = IDX_ZERO;
        cand_s     = IDX_ZERO;
        cand_int_s = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_int_s = int'(ptr_r) + i;
            if (cand_int_s >= N_REQ) begin
                cand_int_s = cand_int_s - N_REQ;
            end else begin
                cand_int_s = cand_int_s;
            end
            cand_s = cand_int_s[IDX_W-1:0];
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // A locked owner keeps the grant while it holds both lock and req.
    always_comb begin
`ifdef FSM_CTX_ARB_LOCK_EN
        hold_s = gnt_valid && lock[gnt_idx] && req[gnt_idx];
`else
        hold_s = 1'b0;
`endif
    end

    // Step the winning context; a simultaneous clear forces s0 and suppresses wrap.
    always_comb begin
        grant_s     = hold_s | found_s;
        grant_idx_s = hold_s ? gnt_idx : win_s;
        cur_s       = ctx_r[grant_idx_s];
        x_s         = x_bits[grant_idx_s];
        clr_w_s     = ctx_clr[grant_idx_s];
        new_state_s = clr_w_s ? S0 : fsm_next(cur_s, x_s);
        wrap_s      = grant_s && !clr_w_s && x_s && (cur_s == S2);
        gnt_nxt_s   = '0;
        if (grant_s) begin
            gnt_nxt_s[grant_idx_s] = 1'b1;
        end else begin
            gnt_nxt_s = '0;
        end
        if (grant_s && !hold_s) begin
            ptr_nxt_s = (grant_idx_s == IDX_LAST) ? IDX_ZERO : (grant_idx_s + IDX_ONE);
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Context store: clears apply to any context, the granted one takes its new state.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                ctx_r[i] <= S0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (ctx_clr[i]) begin
                    ctx_r[i] <= S0;
                end else if (grant_s && (grant_idx_s == IDX_W'(i))) begin
                    ctx_r[i] <= new_state_s;
                end else begin
                    ctx_r[i] <= ctx_r[i];
                end
            end
        end
    end

    // Registered grant outputs and round-robin pointer; index and state hold when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r     <= IDX_ZERO;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= IDX_ZERO;
            state_out <= S0;
            wrap      <= 1'b0;
        end else begin
            ptr_r     <= ptr_nxt_s;
            gnt       <= gnt_nxt_s;
            gnt_valid <= grant_s;
            wrap      <= wrap_s;
            if (grant_s) begin
                gnt_idx   <= grant_idx_s;
                state_out <= new_state_s;
            end else begin
                gnt_idx   <= gnt_idx;
                state_out <= state_out;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_flat
        assign ctx_state[2*g +: 2] = ctx_r[g];
    end

endmodule

// File: tb/tb_fsm_ctx_arbiter.sv
// Scoreboard bench for fsm_ctx_arbiter: directed cycles push expected outputs, a monitor pops after each edge.
// Lock-burst vectors run only when FSM_CTX_ARB_LOCK_EN is defined.
module tb_fsm_ctx_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] x_bits;
    logic [3:0] ctx_clr;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic [1:0] state_out;
    logic       wrap;
    logic [7:0] ctx_state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       v;
        logic [3:0] g;
        logic [1:0] idx;
        logic [1:0] st;
        logic       w;
        logic [7:0] ctx;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_no = 0;

    fsm_ctx_arbiter #(.N_REQ(4), .IDX_W(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .x_bits    (x_bits),
        .ctx_clr   (ctx_clr),
`ifdef FSM_CTX_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .state_out (state_out),
        .wrap      (wrap),
        .ctx_state (ctx_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    // Monitor: one expectation per clock edge, compared 1 time unit after the edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc_no++;
            chk("gnt_valid", cyc_no, {7'd0, gnt_valid}, {7'd0, e.v});
            chk("gnt",       cyc_no, {4'd0, gnt},       {4'd0, e.g});
            chk("gnt_idx",   cyc_no, {6'd0, gnt_idx},   {6'd0, e.idx});
            chk("state_out", cyc_no, {6'd0, state_out}, {6'd0, e.st});
            chk("wrap",      cyc_no, {7'd0, wrap},      {7'd0, e.w});
            chk("ctx_state", cyc_no, ctx_state,         e.ctx);
        end else if (gnt_valid === 1'b1) begin
            chk("unexpected_grant", cyc_no, {7'd0, gnt_valid}, 8'd0);
        end
    end

    task automatic cyc(input logic rs, input logic [3:0] r, input logic [3:0] x,
                       input logic [3:0] c, input logic [3:0] l,
                       input logic ev, input logic [1:0] ei, input logic [1:0] es,
                       input logic ew, input logic [7:0] ec);
        exp_t e;
        @(negedge clock);
        reset   = rs;
        req     = r;
        x_bits  = x;
        ctx_clr = c;
        lock    = l;
        e.v     = ev;
        e.g     = ev ? (4'b0001 << ei) : 4'b0000;
        e.idx   = ei;
        e.st    = es;
        e.w     = ew;
        e.ctx   = ec;
        exp_q.push_back(e);
    endtask

    initial begin
        reset   = 1'b1;
        req     = 4'b0000;
        x_bits  = 4'b0000;
        ctx_clr = 4'b0000;
        lock    = 4'b0000;

        // Reset state
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        // Single requester walks the full sequence, wrap on the 4th step
        cyc(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 2'd3, 1'b0, 8'h03);
        cyc(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 2'd1, 1'b0, 8'h01);
        cyc(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 2'd2, 1'b0, 8'h02);
        cyc(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 2'd0, 1'b1, 8'h00);
        // All request from reset: 0,1,2,3 then pointer back at 0
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        cyc(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 2'd0, 2'd3, 1'b0, 8'h03);
        cyc(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 2'd1, 2'd3, 1'b0, 8'h0F);
        cyc(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 2'd2, 2'd3, 1'b0, 8'h3F);
        cyc(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 2'd3, 2'd3, 1'b0, 8'hFF);
        cyc(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0, 2'd3, 1'b0, 8'hFF);
        // Skip and pointer wrap with req=1010
        cyc(1'b0, 4'hA, 4'hA, 4'h0, 4'h0, 1'b1, 2'd1, 2'd1, 1'b0, 8'hF7);
        cyc(1'b0, 4'hA, 4'hA, 4'h0, 4'h0, 1'b1, 2'd3, 2'd1, 1'b0, 8'h77);
        cyc(1'b0, 4'hA, 4'hA, 4'h0, 4'h0, 1'b1, 2'd1, 2'd2, 1'b0, 8'h7B);
        cyc(1'b0, 4'hA, 4'hA, 4'h0, 4'h0, 1'b1, 2'd3, 2'd2, 1'b0, 8'hBB);
        cyc(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3, 2'd2, 1'b0, 8'hBB);
        // x=0 hold, then idle keeps index/state
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        cyc(1'b0, 4'h2, 4'h2, 4'h0, 4'h0, 1'b1, 2'd1, 2'd3, 1'b0, 8'h0C);
        cyc(1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b1, 2'd1, 2'd3, 1'b0, 8'h0C);
        cyc(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 2'd3, 1'b0, 8'h0C);
        // Clear colliding with grant, clear of a non-granted context
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        cyc(1'b0, 4'h4, 4'h4, 4'h0, 4'h0, 1'b1, 2'd2, 2'd3, 1'b0, 8'h30);
        cyc(1'b0, 4'h4, 4'h4, 4'h0, 4'h0, 1'b1, 2'd2, 2'd1, 1'b0, 8'h10);
        cyc(1'b0, 4'h4, 4'h4, 4'h4, 4'h0, 1'b1, 2'd2, 2'd0, 1'b0, 8'h00);
        cyc(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 2'd3, 1'b0, 8'h03);
        cyc(1'b0, 4'h2, 4'h2, 4'h1, 4'h0, 1'b1, 2'd1, 2'd3, 1'b0, 8'h0C);
        cyc(1'b0, 4'h0, 4'h0, 4'h2, 4'h0, 1'b0, 2'd1, 2'd3, 1'b0, 8'h00);
        // Clear on s2 with x=1 suppresses wrap
        cyc(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 2'd3, 1'b0, 8'h03);
        cyc(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 2'd1, 1'b0, 8'h01);
        cyc(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 2'd2, 1'b0, 8'h02);
        cyc(1'b0, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1, 2'd0, 2'd0, 1'b0, 8'h00);
        // Reset mid-stream overrides active requests, pointer restarts at 0
        cyc(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 2'd1, 2'd3, 1'b0, 8'h0C);
        cyc(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        cyc(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 2'd0, 2'd3, 1'b0, 8'h03);
`ifdef FSM_CTX_ARB_LOCK_EN
        // Locked burst on requester 0, then round-robin resumes at 1
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        cyc(1'b0, 4'h3, 4'h3, 4'h0, 4'h1, 1'b1, 2'd0, 2'd3, 1'b0, 8'h03);
        cyc(1'b0, 4'h3, 4'h3, 4'h0, 4'h1, 1'b1, 2'd0, 2'd1, 1'b0, 8'h01);
        cyc(1'b0, 4'h3, 4'h3, 4'h0, 4'h1, 1'b1, 2'd0, 2'd2, 1'b0, 8'h02);
        cyc(1'b0, 4'h3, 4'h3, 4'h0, 4'h0, 1'b1, 2'd1, 2'd3, 1'b0, 8'h0E);
`endif
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        @(negedge clock);
        @(negedge clock);
        chk("scoreboard_drain", cyc_no, 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_ctx_arbiter.md
Name: fsm_ctx_arbiter

Overview:
- Time-shares one instance of the team's 2-bit mod-4 sequence FSM next-state logic among N_REQ requesters.
- Each requester has its own saved state context. A round-robin scheduler grants one requester per cycle, applies that requester's x bit to its context, and writes the result back.
- Sits between multiple x-stream sources and the shared FSM datapath.
- Replaces N separate FSM copies with one next-state function plus a context store.

Parameters:
- N_REQ, 4, number of requesters/contexts (2..16).
- IDX_W, 2, width of grant index; must satisfy 2**IDX_W >= N_REQ.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester step request.
- x_bits  input  N_REQ  per-requester x_in value, sampled with req.
- ctx_clr  input  N_REQ  per-context synchronous clear to s0.
- gnt  output  N_REQ  one-hot grant, registered.
- gnt_valid  output  1  a grant was issued this cycle.
- gnt_idx  output  IDX_W  index of the granted requester.
- state_out  output  2  new state of the granted context.
- wrap  output  1  granted context completed s2->s0.
- ctx_state  output  2*N_REQ  all contexts, flattened; context i is at [2i+1:2i].

Behaviour:
- Reset:
  - all contexts = s0 (00); round-robin pointer = 0.
  - gnt = 0, gnt_valid = 0, gnt_idx = 0, state_out = 00, wrap = 0.
- Next-state function f(s,x):
  - x=0 holds the state.
  - x=1 advances s0(00)->s3(11)->s1(01)->s2(10)->s0.
- Arbitration (each edge with reset=0):
  - Search req starting at index ptr, ascending, wrapping modulo N_REQ; the first set bit wins (index w).
  - ctx[w] <= f(ctx[w], x_bits[w]).
  - gnt <= one-hot(w), gnt_valid <= 1, gnt_idx <= w, state_out <= the new ctx[w].
  - ptr <= (w+1) mod N_REQ.
- Latency: req/x sampled at edge k; grant, state_out and updated ctx_state are visible after edge k. One step per cycle, fully pipelined, no stall.
- No request: gnt = 0, gnt_valid = 0, gnt_idx and state_out hold their last values, wrap = 0, ptr unchanged, contexts unchanged (except clears).
- Non-granted requesters are not queued. A requester must hold req until it sees its gnt bit; x_bits must be stable while req is held.
- wrap = 1 for exactly the grant cycle in which ctx[w] goes from s2 to s0 with x=1; otherwise 0.
- ctx_clr:
  - Any set bit forces that context to s0 at the edge, independent of grants.
  - If ctx_clr[w] and the grant to w occur together: the clear wins, the grant is still issued and consumed, state_out = 00, wrap = 0, and ptr still advances.
- Reset mid-operation overrides everything, including clears and an in-progress lock.
- ptr wrap: w = N_REQ-1 makes ptr = 0.
- Fairness: a continuously requesting requester is granted within N_REQ cycles.

Optional Feature:
- Macro FSM_CTX_ARB_LOCK_EN.
- When defined:
  - Adds input lock (N_REQ).
  - If the grant owner w had lock[w]=1 and req[w]=1 at the edge, w wins again regardless of ptr, and ptr is not advanced.
  - Lock is released when lock[w] or req[w] drops; normal round-robin then resumes from the stored ptr.
  - A locked requester can therefore apply a multi-bit x burst atomically.
- When undefined: no lock port, pure round-robin as above.

Test Plan:
- Reset, then req=0001 with x=1 for 4 cycles -> gnt_idx=0 every cycle; state_out sequence 11,01,10,00; wrap=1 only on the 4th grant; ctx_state[1:0]=00.
- req=1111, x_bits=1111 for 4 cycles from reset -> gnt_idx 0,1,2,3; each context = 11 afterward; ptr back to 0.
- Pointer wrap and skip: req=1010 held for 4 cycles -> gnt_idx 1,3,1,3; gnt one-hot 0010,1000,...
- x=0 hold: ctx1=11, req=0010 with x=0 -> state_out=11, ctx unchanged, gnt_valid=1. Then req=0 -> gnt_valid=0, state_out stays 11.
- Clear collision: ctx2=01, req=0100 with x=1 and ctx_clr=0100 at the same edge -> gnt_idx=2, state_out=00, wrap=0, ctx2=00. Then assert reset mid-stream -> all outputs and contexts zero the next cycle.
- (FSM_CTX_ARB_LOCK_EN) req=0011, lock=0001 for 3 cycles, then lock=0 -> gnt_idx 0,0,0,1; ctx0 advances 3 steps to 10.
